// File: rtl/ov7670_powerup_seq.sv
// OV7670 power-up sequencer: xclk gating, PWDN/RESET# dwell timing, SCCB config kick with retry/fault.
// Latency: start at edge k -> cfg_start in the cycle after edge k+PWDN_TICKS+RESET_TICKS+SETTLE_TICKS.
// Backpressure: none; start is ignored while a sequence is in flight, cfg_done/cfg_err outside WAIT_CFG.
module ov7670_powerup_seq #(
  parameter int PWDN_TICKS   = 100,
  parameter int RESET_TICKS  = 100,
  parameter int SETTLE_TICKS = 1000,
  parameter int CFG_TIMEOUT  = 100000,
  parameter int MAX_RETRIES  = 3,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          start,
  input  logic          cfg_done,
  input  logic          cfg_err,
  output logic          xclk_en,
  output logic          cam_pwdn,
  output logic          cam_resetn,
  output logic          cfg_start,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state_o
);

  // Dwell counter only has to reach the largest (N-1) among the timed states.
  localparam int MAX_PR = (PWDN_TICKS > RESET_TICKS) ? PWDN_TICKS : RESET_TICKS;
  localparam int MAX_ST = (SETTLE_TICKS > CFG_TIMEOUT) ? SETTLE_TICKS : CFG_TIMEOUT;
  localparam int MAX_T  = (MAX_PR > MAX_ST) ? MAX_PR : MAX_ST;
  localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(PWDN_TICKS - 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_TICKS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CFG_LAST    = CNT_W'(CFG_TIMEOUT - 1);
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PWDN     = 3'd1,
    S_RST      = 3'd2,
    S_SETTLE   = 3'd3,
    S_CONFIG   = 3'd4,
    S_WAIT_CFG = 3'd5,
    S_READY    = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             timed;

  // State, dwell counter and retry count registers; reset aborts any sequence at once.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Next-state, retry and dwell-counter logic.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = '0;
    timed   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PWDN;
          retry_d = '0;
        end
      end
      S_PWDN: begin
        timed = 1'b1;
        if (cnt_q == PWDN_LAST) state_d = S_RST;
      end
      S_RST: begin
        timed = 1'b1;
        if (cnt_q == RESET_LAST) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        timed = 1'b1;
        if (cnt_q == SETTLE_LAST) state_d = S_CONFIG;
      end
      S_CONFIG: begin
        state_d = S_WAIT_CFG;
      end
      S_WAIT_CFG: begin
        timed = 1'b1;
        // Error beats done; done beats a coincident timeout.
        if (cfg_err || (!cfg_done && (cnt_q == CFG_LAST))) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_RST;
          end else begin
            state_d = S_FAULT;
          end
        end else if (cfg_done) begin
          state_d = S_READY;
        end
      end
      S_READY, S_FAULT: begin
        if (start) begin
          state_d = S_PWDN;
          retry_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Counter restarts on every transition; untimed states keep it parked at zero.
    if (state_d == state_q && timed) cnt_d = cnt_q + CNT_W'(1);
  end

  // Moore output decode from the state register only.
  always_comb begin
    xclk_en    = 1'b1;
    cam_pwdn   = 1'b0;
    cam_resetn = 1'b1;
    cfg_start  = 1'b0;
    ready      = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_IDLE: begin
        xclk_en    = 1'b0;
        cam_pwdn   = 1'b1;
        cam_resetn = 1'b0;
      end
      S_PWDN: begin
        cam_pwdn   = 1'b1;
        cam_resetn = 1'b0;
      end
      S_RST:    cam_resetn = 1'b0;
      S_CONFIG: cfg_start  = 1'b1;
      S_READY:  ready      = 1'b1;
      S_FAULT: begin
        xclk_en    = 1'b0;
        cam_pwdn   = 1'b1;
        cam_resetn = 1'b0;
        fault      = 1'b1;
      end
      default: ;
    endcase
  end

  assign retry_cnt = retry_q;
  assign state_o   = state_q;

endmodule
